// File: rtl/leorv32_lsu.sv
// LeoRV32 load/store unit: one access at a time, single-outstanding bus.
// Checks func3/alignment, drives byte strobes, extends load data.
//
// Ports:
//   i_clk, i_reset_n          clock, async active-low reset
//   i_req_* / o_req_ready     access request from execute stage
//   o_resp_*                  one-cycle completion pulse, data, error
//   o_mem_* / i_mem_*         valid/ready data bus, word addressed
//   TIMEOUT                   bus wait limit in cycles, 0 = no limit
module leorv32_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_store,
  input  logic [2:0]  i_req_func3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_error,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_write,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_func3;
  logic [1:0]    r_off;
  logic          r_store;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_error;
  logic          r_mem_valid;
  logic [31:0]   r_mem_addr;
  logic          r_mem_write;
  logic [3:0]    r_mem_wstrb;
  logic [31:0]   r_mem_wdata;

  logic          w_byte;
  logic          w_half;
  logic          w_word;
  logic          w_ill;
  logic          w_mis;
  logic          w_err;
  logic [31:0]   w_wdata;
  logic [3:0]    w_strb;
  logic [31:0]   w_sh;
  logic [31:0]   w_ld;
  logic [CW-1:0] w_cnt_inc;
  logic          w_tmo;

  assign w_byte = (i_req_func3[1:0] == 2'b00);
  assign w_half = (i_req_func3[1:0] == 2'b01);
  assign w_word = (i_req_func3[1:0] == 2'b10);

  // Loads allow 000,001,010,100,101; stores allow 000,001,010.
  assign w_ill = i_req_store
               ? (i_req_func3 > 3'd2)
               : ((i_req_func3 == 3'b011) ||
                  (i_req_func3[2:1] == 2'b11));
  assign w_mis = (w_half & i_req_addr[0]) |
                 (w_word & (|i_req_addr[1:0]));
  assign w_err = w_ill | w_mis;

  always_comb begin
    w_wdata = i_req_wdata;
    w_strb  = 4'b1111;
    unique case (1'b1)
      w_byte: begin
        w_wdata = {4{i_req_wdata[7:0]}};
        w_strb  = 4'b0001 << i_req_addr[1:0];
      end
      w_half: begin
        w_wdata = {2{i_req_wdata[15:0]}};
        w_strb  = i_req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend.
  always_comb begin
    w_sh = i_mem_rdata >> {r_off, 3'b000};
    w_ld = w_sh;
    unique case (1'b1)
      (r_func3 == 3'b000): w_ld = {{24{w_sh[7]}}, w_sh[7:0]};
      (r_func3 == 3'b001): w_ld = {{16{w_sh[15]}}, w_sh[15:0]};
      (r_func3 == 3'b100): w_ld = {24'd0, w_sh[7:0]};
      (r_func3 == 3'b101): w_ld = {16'd0, w_sh[15:0]};
      default:             w_ld = w_sh;
    endcase
  end

  // Timeout fires on the cycle the count would reach TIMEOUT;
  // a concurrent mem_ready takes priority in the FSM.
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_tmo = (TIMEOUT != 0) && (w_cnt_inc == CW'(TIMEOUT));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_func3      <= '0;
      r_off        <= '0;
      r_store      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_write  <= 1'b0;
      r_mem_wstrb  <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_func3 <= i_req_func3;
            r_off   <= i_req_addr[1:0];
            r_store <= i_req_store;
            if (w_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state     <= S_BUS;
              r_cnt       <= '0;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= {i_req_addr[31:2], 2'b00};
              r_mem_write <= i_req_store;
              r_mem_wstrb <= i_req_store ? w_strb : 4'b0000;
              r_mem_wdata <= i_req_store ? w_wdata : '0;
            end
          end
        end
        S_BUS: begin
          if (i_mem_ready) begin
            r_state      <= S_RESP;
            r_mem_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b0;
            r_resp_rdata <= r_store ? '0 : w_ld;
          end else if (w_tmo) begin
            r_state      <= S_RESP;
            r_mem_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_error = r_resp_error;
  assign o_mem_valid  = r_mem_valid;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_write  = r_mem_write;
  assign o_mem_wstrb  = r_mem_wstrb;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: doc/leorv32_lsu.md
# leorv32_lsu

Load/store sequencer for the LeoRV32 core. It accepts one decoded OP_LOAD or OP_STORE access at a time and checks alignment and func3 legality. It drives a single-outstanding valid/ready memory bus with byte strobes and returns sign- or zero-extended load data. It sits between the execute stage and the SoC data bus, and it flags misaligned, illegal or timed-out accesses instead of hanging the core.

## Interface
- TIMEOUT, 255: bus cycles to wait for mem_ready before aborting; 0 disables the timeout.

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents an access
- req_ready  out  1  LSU idle and accepting; high only in IDLE
- req_store  in  1  1 = store (FUNC_SB/SH/SW), 0 = load (FUNC_LB/LH/LW/LBU/LHU)
- req_func3  in  3  instruction func3
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data, rs2
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  qualifies resp_valid: misaligned, illegal func3 or timeout
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_write  out  1  1 = write
- mem_wstrb  out  4  byte enables; 0000 for reads
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  32  read data, sampled when mem_valid && mem_ready

## Operation
- The FSM has three states: IDLE, BUS and RESP. Reset enters IDLE.
- IDLE: req_ready = 1. A request is accepted when req_valid is high on a rising edge. The LSU latches addr[1:0], func3, store and the wdata lanes.
- Error check at acceptance:
  - Load func3 values 011, 110 and 111 are illegal.
  - Store func3 values other than 000, 001 and 010 are illegal.
  - Halfword access with addr[0] = 1 is misaligned.
  - Word access with addr[1:0] ≠ 00 is misaligned.
  - On any error the FSM goes to RESP with resp_error = 1, and no bus access is made.
- Legal access: the FSM goes to BUS, and mem_valid, mem_addr, mem_write, mem_wstrb and mem_wdata are registered.
- Store lanes:
  - SB: wdata = {4{b}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, wstrb = 0011 (addr[1] = 0) or 1100 (addr[1] = 1).
  - SW: wstrb = 1111.
- BUS: mem_valid and all mem_* outputs are held stable until mem_ready.
  - On mem_valid && mem_ready, mem_valid drops the same edge and the FSM goes to RESP.
  - Loads capture mem_rdata >> (8 × addr[1:0]). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- Timeout: a counter of $clog2(TIMEOUT+1) bits clears on entry to BUS and increments each BUS cycle without mem_ready.
  - When the count reaches TIMEOUT, mem_valid drops and the FSM goes to RESP with resp_error = 1 and resp_rdata = 0.
  - If mem_ready arrives in the same cycle the count reaches TIMEOUT, mem_ready wins and the access completes normally.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. resp_rdata and resp_error are registered and hold until the next RESP.
- Responses are always accepted; the core has no backpressure on the response.

## Timing
- Reset values:
  - state = IDLE, so req_ready = 1.
  - mem_valid, mem_write and resp_valid = 0.
  - resp_error = 0.
  - mem_addr, mem_wstrb, mem_wdata and resp_rdata = 0.
  - The timeout counter = 0.
- Accept at edge 0 puts mem_valid high after edge 0. mem_ready at edge 1 gives resp_valid after edge 1; minimum latency is 2 cycles from accept to response.
- Each wait state adds one cycle.
- An error request gives resp_valid in the cycle after acceptance (latency 1), with no mem_valid.
- Throughput: a new request can be accepted at the edge after resp_valid. Back-to-back accesses therefore cost 3 cycles each with zero wait states.
- Reset mid-BUS aborts immediately: mem_valid = 0 and no response is issued. The bus side must tolerate the dropped request.
- mem_ready while mem_valid = 0 is ignored.

## Test plan
- LB at addr 0x1003 with mem_rdata = 0x80FF_0000 → mem_addr = 0x1000, mem_wstrb = 0000, resp_rdata = 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x2002 with wdata = 0x1234_ABCD, mem_ready after 3 wait states → mem_wdata = 0xABCD_ABCD, mem_wstrb = 1100, mem_* stable for 4 cycles, resp_valid 1 cycle later, resp_rdata = 0.
- LW at 0x3001 → resp_valid with resp_error = 1 in the next cycle, mem_valid never asserted. Store with func3 = 011 → same behaviour.
- TIMEOUT = 4, load with mem_ready held low → mem_valid high for 4 cycles then drops; resp_error = 1, resp_rdata = 0.
  - Repeat with mem_ready arriving in the cycle the count reaches TIMEOUT → normal completion.
- Back-to-back SW 0x0 / LW 0x4 with zero wait states → responses 3 cycles apart, req_ready low outside IDLE.
- reset_n asserted during BUS → mem_valid falls asynchronously, no resp_valid. After release, req_ready = 1 and the next access completes normally.
